// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_queue
//  Brief    : Instruction fetch unit feeding decode through a small FIFO with
//             credit-based read issue, redirect flush and end-of-program halt.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] EOF_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [31:0] imem_index,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int unsigned       c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_CNT_ONE  = 1;
    localparam logic [c_AW+1:0]   c_DEPTH_W  = (c_AW+2)'(DEPTH);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     infl_pc_q;
    logic            infl_q;
    logic            kill_q;
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_AW:0]   count_q, count_d;
    logic [31:0]     fetch_count_q;
    logic [31:0]     ent_instr_q [DEPTH];
    logic [31:0]     ent_pc_q    [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_eof_ret;
    logic            w_credit;
    logic [c_AW+1:0] w_occ;
    logic [1:0]      w_unused_pc_lsb;

    assign w_unused_pc_lsb = redirect_pc[1:0];

    // A returning word is dropped if its read was killed or a flush lands this cycle.
    assign w_push    = infl_q & ~kill_q & ~redirect;
    assign w_eof_ret = w_push & (imem_data == EOF_WORD);
    assign w_occ     = {1'b0, count_q} + {{(c_AW+1){1'b0}}, infl_q};
    assign w_credit  = (w_occ < c_DEPTH_W);

    // Stopping on the EOF return itself keeps any read past the marker from issuing.
    assign imem_rd_en  = ~rst & (state_q == S_RUN) & ~redirect & ~w_eof_ret & w_credit;
    assign imem_index  = {2'b00, fetch_pc_q[31:2]};
    assign out_valid   = ~rst & (count_q != '0);
    assign w_pop       = out_valid & out_ready;
    assign out_instr   = out_valid ? ent_instr_q[rd_ptr_q] : 32'h0000_0000;
    assign out_pc      = out_valid ? ent_pc_q[rd_ptr_q]    : 32'h0000_0000;
    assign halted      = ~rst & (state_q == S_HALT);
    assign fetch_count = fetch_count_q;

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = S_RUN;
        end else if (w_eof_ret) begin
            state_d = S_HALT;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (imem_rd_en) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q       <= S_RUN;
            fetch_pc_q    <= 32'h0000_0000;
            infl_pc_q     <= 32'h0000_0000;
            infl_q        <= 1'b0;
            kill_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            infl_q     <= imem_rd_en;
            kill_q     <= redirect & imem_rd_en;
            if (imem_rd_en) begin
                infl_pc_q <= fetch_pc_q;
            end
            if (w_push) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            ent_instr_q[wr_ptr_q] <= imem_data;
            ent_pc_q[wr_ptr_q]    <= infl_pc_q;
        end
    end

endmodule
`default_nettype wire

// File: doc/riscv_fetch_queue.md
RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter EOF_WORD, default 32'hFFFF_FFFF, meaning the end-of-program marker.
REQ-003 SHALL have port CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_rd_en  output  1  instruction-RAM read enable.
REQ-006 SHALL have port imem_index  output  32  instruction-RAM word index, equal to fetch PC >> 2.
REQ-007 SHALL have port imem_data  input  32  RAM read data, valid the cycle after imem_rd_en=1.
REQ-008 SHALL have port redirect  input  1  one-cycle branch/jump redirect pulse from execute.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port out_valid  output  1  head entry is valid toward decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-012 SHALL have port out_instr  output  32  head instruction word.
REQ-013 SHALL have port out_pc  output  32  byte address of the head instruction.
REQ-014 SHALL have port halted  output  1  fetch stopped after fetching EOF_WORD.
REQ-015 SHALL have port fetch_count  output  32  number of words enqueued since reset.

Function
REQ-016 SHALL implement two states, RUN and HALT; reset enters RUN.
REQ-017 In RUN, imem_rd_en SHALL be 1 iff (occupancy + in-flight reads) < DEPTH and redirect=0; each issued read SHALL advance fetch PC by 4, wrapping modulo 2^32.
REQ-018 At most one read SHALL be in flight per cycle; the RAM returns each read with fixed 1-cycle latency.
REQ-019 A returned word SHALL be written into the FIFO tail with its PC at the end of the return cycle; out_valid SHALL rise the cycle after.
REQ-020 Transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; the head is popped at that edge.
REQ-021 Simultaneous push and pop, including when full, SHALL be legal and leave occupancy unchanged.
REQ-022 The credit rule in REQ-017 SHALL guarantee that no overflow ever occurs; a pop on empty SHALL never occur because out_valid=0.
REQ-023 out_instr and out_pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 When a returned word equals EOF_WORD, it SHALL be enqueued normally, and the state SHALL become HALT.
REQ-025 In HALT: imem_rd_en=0, halted=1, and queued entries still drain to decode.
REQ-026 On redirect=1 (either state), the block SHALL:
- flush all FIFO entries;
- mark any in-flight read killed, so its data is discarded next cycle;
- set fetch PC to {redirect_pc[31:2],2'b00};
- enter RUN.
REQ-027 On a redirect cycle, out_valid SHALL be 0 the following cycle, and the first read of the target SHALL issue that following cycle.
REQ-028 If redirect coincides with out_ready, the pop SHALL still be honored for the current head; the flush then applies.
REQ-029 fetch_count SHALL increment by 1 per non-killed enqueue, wrapping at 2^32.
REQ-030 When out_valid=0, out_instr SHALL be 32'h0000_0000 (NOP) and out_pc SHALL be 0.

Reset
REQ-031 With rst=1 at a rising edge, the block SHALL set: PC=0, FIFO empty, in-flight cleared, kill flag cleared, state RUN, fetch_count=0.
REQ-032 Outputs during and after the reset edge SHALL be: out_valid=0, out_instr=0, out_pc=0, halted=0, imem_rd_en=0.
REQ-033 In the first cycle after rst deasserts, imem_rd_en SHALL be 1 with imem_index=0.
REQ-034 rst SHALL override redirect and any in-progress fill or drain.

Verification
REQ-035 Release reset, RAM word0=32'h00500093, out_ready=1 -> imem_rd_en at cycle 0 with index 0; out_valid at cycle 2 with out_pc=0 and out_instr=32'h00500093; then one instruction per cycle.
REQ-036 Hold out_ready=0 for 10 cycles -> exactly DEPTH=4 reads issued, out_valid held, head stable at pc 0. Then assert out_ready -> entries pc 0,4,8,12 delivered in order with no gaps.
REQ-037 Assert redirect with redirect_pc=32'h40 while the FIFO holds 3 entries and 1 read is in flight -> next cycle out_valid=0 and index=16. The killed word is never output, and fetch_count excludes it.
REQ-038 Place EOF_WORD at index 5 -> words 0..5 delivered, halted=1, no read beyond index 5. A subsequent redirect to 0 -> halted=0 and fetch resumes at index 0.
REQ-039 Assert rst mid-stream with a full FIFO -> all outputs return to their REQ-031/REQ-032 values the next cycle, and fetch_count=0.
REQ-040 Redirect to 32'hFFFF_FFFC with out_ready=1 -> outputs out_pc FFFF_FFFC then out_pc 0, confirming PC wrap.
